mult_acc: RTL and testbench
===========================

# mult_acc

Accumulating stage directly downstream of the clocked multiplier. It consumes the registered `2*SW`-bit unsigned products and sums each burst of `LEN` consecutive accepted products into one widened result, with no loss of precision. Each result is presented on a valid/ready output register. That register is double-buffered against the running sum, so accumulation of the next burst proceeds while the previous result waits for its consumer.

## Interface
- `SW`, default 24: operand width of the upstream multiplier; product width is `2*SW`.
- `LEN`, default 8: number of products per burst. Legal range: `LEN >= 2`.
- `GW`: derived localparam, `$clog2(LEN)`; number of guard bits.
- `AW`: derived localparam, `2*SW+GW`; accumulator and result width.
- `clk` — in — 1 — sole clock. All state updates on `posedge clk`.
- `rst` — in — 1 — reset; asynchronous, active-high.
- `prod_valid` — in — 1 — `DatP` holds a valid product this cycle.
- `prod_ready` — out — 1 — block accepts `DatP` this cycle.
- `DatP` — in — `2*SW` — unsigned product from the multiplier.
- `clear` — in — 1 — synchronous abort of the burst in progress.
- `acc_valid` — out — 1 — `DatS` holds a completed sum.
- `acc_ready` — in — 1 — consumer takes `DatS` this cycle.
- `DatS` — out — `AW` — burst sum, unsigned.
- `busy` — out — 1 — a partial burst is held (`state == S_RUN`).

## Operation
- **FSM states:** `S_IDLE` (`cnt=0`, `acc=0`) and `S_RUN` (`1 <= cnt <= LEN-1`). `cnt` is `GW` bits wide.
- **Accept:** a product is accepted when `prod_valid && prod_ready && !clear`.
- **Non-final accept** (`cnt < LEN-1`): `acc <= acc + DatP`, `cnt <= cnt+1`, state becomes `S_RUN`.
- **Final accept** (`cnt == LEN-1`): `DatS <= acc + DatP`, `acc_valid <= 1`, `acc <= 0`, `cnt <= 0`, state becomes `S_IDLE`.
- **Width:** the sum is zero-extended to `AW` bits. `LEN*(2^(2*SW)-1) < 2^AW`, so no overflow or saturation logic is needed.
- **`prod_ready`** is combinational: `!(cnt == LEN-1 && acc_valid && !acc_ready)`. Only the final product of a burst can stall, and only while the output register is occupied and not draining.
- **Output register:**
  - `acc_valid` clears on `acc_valid && acc_ready`, unless a final accept loads a new result on the same edge; in that case `acc_valid` stays 1 and `DatS` takes the new sum.
  - `DatS` holds its value while `acc_valid && !acc_ready`.
- **`clear`:**
  - Wins over accept: `acc <= 0`, `cnt <= 0`, state becomes `S_IDLE`, and the product presented that cycle is dropped.
  - The output register and its handshake are unaffected.
- **Gaps:** cycles with `prod_valid = 0` leave `acc` and `cnt` unchanged. Bursts may be interleaved with idle cycles arbitrarily.
- **Upstream alignment:** the multiplier's output is registered, so upstream control asserts `prod_valid` one cycle after it presents operands.

## Timing
- **Reset values:** `acc_valid=0`, `DatS=0`, `busy=0`, `cnt=0`, `acc=0`. `prod_ready=1` immediately after reset.
- **Latency:** `DatS` and `acc_valid` are valid the cycle after the edge that accepts the final product.
- **Throughput:** one product per cycle. Back-to-back bursts sustain full rate while `acc_ready=1`.
- **Reset mid-burst:** partial sum and any pending result are discarded asynchronously. The first accept after reset starts a new burst.
- **Stall release:** the edge where `acc_ready=1` drains the old result. If the final product is also presented that edge, it is accepted and the new result is valid the next cycle with no bubble.

## Structure
- **Shared package/header `mult_acc_pkg`:**
  - state encoding `S_IDLE=1'b0`, `S_RUN=1'b1`;
  - helper for the `GW`/`AW` derivation, reused by future adder-tree stages.
- **Sub-module `acc_out_reg`:** a one-entry valid/ready holding register, parameterized on width, that owns `acc_valid` and `DatS`. `mult_acc` keeps the FSM, counter and adder.

## Test plan
Unless stated otherwise, `SW=4`, `LEN=4`, `AW=10`.
- **Basic sum:** `DatP` = 3, 5, 7, 9 on consecutive cycles with `acc_ready=1` → `DatS=24`, `acc_valid` high exactly one cycle, the cycle after the 4th accept.
- **Maximum value:** four products of 225 → `DatS=900`, no wrap. `SW=24`, `LEN=8`, all products `2^48-1` → `DatS = 8*(2^48-1)`.
- **Backpressure:** first burst sums to 24 with `acc_ready=0`; second burst of 1, 1, 1, 1 → `prod_ready` drops while the 4th product waits. Raise `acc_ready` → 24 drains the same edge the 4th product is accepted, then `DatS=4`.
- **Clear:** after 2 products (10, 20), pulse `clear` with `prod_valid=1` and `DatP=99` → 99 is dropped and `busy=0`. Next burst 1, 2, 3, 4 → `DatS=10`.
- **Reset mid-burst:** 2 products accepted and a previous result pending → assert `rst` asynchronously mid-cycle → all outputs read 0 at once, `prod_ready=1`. The next four products sum correctly.
- **Gaps:** products 6, 0, 6, 0 with random `prod_valid` gaps of 0–3 cycles → `DatS=12`, `cnt` holds across gaps.

Source files
------------

// File: rtl/mult_acc_pkg.sv
// Shared types and width helpers for the product accumulator and later adder-tree stages.
package mult_acc_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Guard bits needed to sum len terms without overflow.
    function automatic int acc_gw(input int len);
        return $clog2(len);
    endfunction

    // Width of a sum of len products of two sw-bit operands.
    function automatic int acc_aw(input int sw, input int len);
        return 2 * sw + acc_gw(len);
    endfunction

endpackage

// File: rtl/mult_acc_if.sv
// Product input and sum output handshakes of the accumulator.
interface mult_acc_if
    import mult_acc_pkg::*;
#(
    parameter int SW  = 24,
    parameter int LEN = 8
);
    localparam int AW = acc_aw(SW, LEN);

    logic            prod_valid;
    logic            prod_ready;
    logic [2*SW-1:0] DatP;
    logic            clear;
    logic            acc_valid;
    logic            acc_ready;
    logic [AW-1:0]   DatS;
    logic            busy;

    modport master (
        output prod_valid, DatP, clear, acc_ready,
        input  prod_ready, acc_valid, DatS, busy
    );

    modport slave (
        input  prod_valid, DatP, clear, acc_ready,
        output prod_ready, acc_valid, DatS, busy
    );
endinterface

// File: rtl/mult_acc_out_reg.sv
// One-entry valid/ready holding register for completed burst sums.
module acc_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);

    // A load wins over a drain on the same edge so back-to-back results need no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_acc.sv
// Sums each burst of LEN accepted products into one widened result.
module mult_acc
    import mult_acc_pkg::*;
#(
    parameter int SW  = 24,
    parameter int LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    mult_acc_if.slave  bus
);

    localparam int GW = acc_gw(LEN);
    localparam int AW = acc_aw(SW, LEN);

    state_t        state;
    logic [GW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic          last;
    logic          accept;
    logic          load;

    assign last   = (cnt == GW'(LEN - 1));
    // Only the closing product can stall, and only while the result slot is full and not draining.
    assign bus.prod_ready = !(last && bus.acc_valid && !bus.acc_ready);
    assign accept = bus.prod_valid && bus.prod_ready && !bus.clear;
    assign load   = accept && last;
    assign sum    = acc + AW'(bus.DatP);
    assign bus.busy = (state == S_RUN);

    // Burst FSM: count accepted products, clear aborts the partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else if (bus.clear) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            if (last) begin
                state <= S_IDLE;
                cnt   <= '0;
                acc   <= '0;
            end else begin
                state <= S_RUN;
                cnt   <= cnt + GW'(1);
                acc   <= sum;
            end
        end
    end

    acc_out_reg #(.W(AW)) u_out (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (sum),
        .ready (bus.acc_ready),
        .valid (bus.acc_valid),
        .dout  (bus.DatS)
    );

endmodule

// File: tb/tb_mult_acc.sv
// Directed checks of mult_acc: small config plus a full-width max-value burst.
module tb_mult_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_acc_if #(.SW(4),  .LEN(4)) b  ();
    mult_acc_if #(.SW(24), .LEN(8)) b2 ();

    mult_acc #(.SW(4),  .LEN(4)) dut  (.clk(clk), .rst(rst), .bus(b));
    mult_acc #(.SW(24), .LEN(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one product for exactly one edge.
    task automatic push(input logic [7:0] d);
        b.prod_valid = 1'b1;
        b.DatP       = d;
        step();
        b.prod_valid = 1'b0;
    endtask

    logic [63:0] maxp;

    initial begin
        b.prod_valid  = 0; b.DatP  = '0; b.clear  = 0; b.acc_ready  = 1;
        b2.prod_valid = 0; b2.DatP = '0; b2.clear = 0; b2.acc_ready = 1;
        #3;
        chk("rst_valid", 64'(b.acc_valid), 0);
        chk("rst_dats",  64'(b.DatS), 0);
        chk("rst_busy",  64'(b.busy), 0);
        chk("rst_ready", 64'(b.prod_ready), 1);
        step();
        rst = 0;

        // Full-width burst: eight all-ones products.
        maxp = 64'h0000_FFFF_FFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            b2.prod_valid = 1; b2.DatP = maxp[47:0];
            step();
        end
        b2.prod_valid = 0;
        chk("max48_valid", 64'(b2.acc_valid), 1);
        chk("max48_sum",   64'(b2.DatS), 8 * maxp);

        // Basic sum, single-cycle valid.
        push(3); push(5); push(7);
        chk("basic_pre_valid", 64'(b.acc_valid), 0);
        chk("basic_busy", 64'(b.busy), 1);
        push(9);
        chk("basic_valid", 64'(b.acc_valid), 1);
        chk("basic_sum",   64'(b.DatS), 24);
        chk("basic_busy0", 64'(b.busy), 0);
        step();
        chk("basic_valid_drop", 64'(b.acc_valid), 0);

        // Maximum value for small config.
        for (int i = 0; i < 4; i++) push(225);
        chk("max8_sum", 64'(b.DatS), 900);
        step();

        // Backpressure: 24 held, second burst stalls on its last product.
        b.acc_ready = 0;
        push(3); push(5); push(7); push(9);
        chk("bp_valid", 64'(b.acc_valid), 1);
        chk("bp_sum1",  64'(b.DatS), 24);
        push(1); push(1); push(1);
        b.prod_valid = 1; b.DatP = 1;
        #1;
        chk("bp_stall", 64'(b.prod_ready), 0);
        step();
        chk("bp_hold_dats", 64'(b.DatS), 24);
        chk("bp_hold_cnt",  64'(dut.cnt), 3);
        chk("bp_stall2",    64'(b.prod_ready), 0);
        b.acc_ready = 1;
        #1;
        chk("bp_release", 64'(b.prod_ready), 1);
        step();
        b.prod_valid = 0;
        chk("bp_valid2", 64'(b.acc_valid), 1);
        chk("bp_sum2",   64'(b.DatS), 4);
        step();
        chk("bp_drain", 64'(b.acc_valid), 0);

        // Clear drops the presented product and the partial sum.
        push(10); push(20);
        chk("clr_busy1", 64'(b.busy), 1);
        b.prod_valid = 1; b.DatP = 99; b.clear = 1;
        step();
        b.prod_valid = 0; b.clear = 0;
        chk("clr_busy0", 64'(b.busy), 0);
        chk("clr_cnt",   64'(dut.cnt), 0);
        chk("clr_valid", 64'(b.acc_valid), 0);
        push(1); push(2); push(3); push(4);
        chk("clr_sum", 64'(b.DatS), 10);
        step();

        // Async reset with a pending result and a partial burst.
        b.acc_ready = 0;
        push(1); push(1); push(1); push(1);
        push(2); push(2);
        chk("mr_pending", 64'(b.acc_valid), 1);
        #2 rst = 1;
        #1;
        chk("mr_valid", 64'(b.acc_valid), 0);
        chk("mr_dats",  64'(b.DatS), 0);
        chk("mr_busy",  64'(b.busy), 0);
        chk("mr_ready", 64'(b.prod_ready), 1);
        step();
        rst = 0;
        b.acc_ready = 1;
        push(5); push(6); push(7); push(8);
        chk("mr_sum", 64'(b.DatS), 26);
        step();

        // Random idle gaps between products; count must hold across them.
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            chk("gap_cnt", 64'(dut.cnt), 64'(k));
            push((k % 2 == 0) ? 8'd6 : 8'd0);
        end
        chk("gap_valid", 64'(b.acc_valid), 1);
        chk("gap_sum",   64'(b.DatS), 12);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
